// File: rtl/eeg_chip_rx.sv
// eeg_chip_rx: pad-side receive stage. Packs narrow chip beats into wide words,
// then routes each completed word through a one-word stage register to either
// the data FIFO (toward the accelerator) or the command register (toward config).
module eeg_chip_rx #(
  parameter int CHIP_DAT_DW = 8,
  parameter int OUT_DW      = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chip_dat_vld,
  input  logic                   chip_dat_lst,
  input  logic [CHIP_DAT_DW-1:0] chip_dat_dat,
  input  logic                   chip_dat_cmd,
  output logic                   chip_dat_rdy,
  output logic                   dat_vld,
  output logic                   dat_lst,
  output logic [OUT_DW-1:0]      dat_dat,
  input  logic                   dat_rdy,
  output logic                   cmd_vld,
  output logic                   cmd_lst,
  output logic [OUT_DW-1:0]      cmd_dat,
  input  logic                   cmd_rdy
);

  localparam int RATIO = OUT_DW / CHIP_DAT_DW;
  localparam int CNT_W = $clog2(RATIO);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  // packer state
  logic [OUT_DW-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              in_pkt;
  logic              pkt_cmd;

  // stage register between packer and the two destinations
  logic              stage_vld;
  logic              stage_lst;
  logic              stage_cmd;
  logic [OUT_DW-1:0] stage_dat;

  // keeps chip_dat_rdy low while reset is asserted and for the release cycle
  logic              rdy_en;

  // data FIFO; each entry carries {lst, word}
  logic [OUT_DW:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_push;
  logic              cmd_load;
  logic              stage_push;
  logic              beat_acc;
  logic              word_done;
  logic              cur_cmd;
  logic [OUT_DW-1:0] word_nxt;

  // handshakes, stage drain decision and the word being assembled this beat
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    fifo_pop   = !fifo_empty && dat_rdy;
    // a pop frees a slot in the same cycle, so a full FIFO can still accept
    cmd_load   = stage_vld && stage_cmd && (!cmd_vld || cmd_rdy);
    fifo_push  = stage_vld && !stage_cmd && (!fifo_full || fifo_pop);
    stage_push = cmd_load || fifo_push;

    chip_dat_rdy = rdy_en && (!stage_vld || stage_push);
    beat_acc     = chip_dat_vld && chip_dat_rdy;
    word_done    = beat_acc && (chip_dat_lst || (cnt == CNT_LAST));
    cur_cmd      = in_pkt ? pkt_cmd : chip_dat_cmd;

    // starting from zero on beat 0 keeps bits above the last beat cleared
    word_nxt = (cnt == '0) ? '0 : sreg;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) begin
        word_nxt[k*CHIP_DAT_DW +: CHIP_DAT_DW] = chip_dat_dat;
      end
    end

    dat_vld = !fifo_empty;
    {dat_lst, dat_dat} = fifo_mem[rd_ptr[PTR_W-1:0]];
  end

  // ready enable comes up one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // packer: beat counter, partial word and packet type tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      in_pkt  <= 1'b0;
      pkt_cmd <= 1'b0;
    end else if (beat_acc) begin
      if (!in_pkt) begin
        pkt_cmd <= chip_dat_cmd;
      end
      if (word_done) begin
        sreg   <= '0;
        cnt    <= '0;
        in_pkt <= !chip_dat_lst;
      end else begin
        sreg   <= word_nxt;
        cnt    <= cnt + 1'b1;
        in_pkt <= 1'b1;
      end
    end
  end

  // stage: captures each completed word, empties when a destination takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= 1'b0;
      stage_lst <= 1'b0;
      stage_cmd <= 1'b0;
      stage_dat <= '0;
    end else if (word_done) begin
      stage_vld <= 1'b1;
      stage_lst <= chip_dat_lst;
      stage_cmd <= cur_cmd;
      stage_dat <= word_nxt;
    end else if (stage_push) begin
      stage_vld <= 1'b0;
    end
  end

  // data FIFO storage and pointers; storage is cleared so outputs read 0 in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= {stage_lst, stage_dat};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // command register: holds one word until the config side takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld <= 1'b0;
      cmd_lst <= 1'b0;
      cmd_dat <= '0;
    end else if (cmd_load) begin
      cmd_vld <= 1'b1;
      cmd_lst <= stage_lst;
      cmd_dat <= stage_dat;
    end else if (cmd_rdy) begin
      cmd_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eeg_chip_rx.sv
// tb_eeg_chip_rx: directed and randomized checks of eeg_chip_rx against a
// packet-level packing model.
module tb_eeg_chip_rx;

  localparam int DW = 8;
  localparam int OW = 32;
  localparam int R  = OW / DW;

  logic          clk;
  logic          rst_n;
  logic          chip_dat_vld;
  logic          chip_dat_lst;
  logic [DW-1:0] chip_dat_dat;
  logic          chip_dat_cmd;
  logic          chip_dat_rdy;
  logic          dat_vld;
  logic          dat_lst;
  logic [OW-1:0] dat_dat;
  logic          dat_rdy;
  logic          cmd_vld;
  logic          cmd_lst;
  logic [OW-1:0] cmd_dat;
  logic          cmd_rdy;

  int checks;
  int errors;
  bit rand_mode;

  logic [OW:0] obs_dat[$];
  logic [OW:0] obs_cmd[$];
  logic [OW:0] exp_dat[$];
  logic [OW:0] exp_cmd[$];

  eeg_chip_rx #(.CHIP_DAT_DW(DW), .OUT_DW(OW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chip_dat_vld (chip_dat_vld),
    .chip_dat_lst (chip_dat_lst),
    .chip_dat_dat (chip_dat_dat),
    .chip_dat_cmd (chip_dat_cmd),
    .chip_dat_rdy (chip_dat_rdy),
    .dat_vld      (dat_vld),
    .dat_lst      (dat_lst),
    .dat_dat      (dat_dat),
    .dat_rdy      (dat_rdy),
    .cmd_vld      (cmd_vld),
    .cmd_lst      (cmd_lst),
    .cmd_dat      (cmd_dat),
    .cmd_rdy      (cmd_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every completed output handshake (inputs only change just after posedge)
  always @(negedge clk) begin
    if (rst_n) begin
      if (dat_vld && dat_rdy) obs_dat.push_back({dat_lst, dat_dat});
      if (cmd_vld && cmd_rdy) obs_cmd.push_back({cmd_lst, cmd_dat});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      dat_rdy = 1'($urandom_range(0, 1));
      cmd_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  // reference model: split a packet into R-beat words, first beat in the LSBs,
  // zero padding above a short tail, lst on the final word of the packet
  task automatic model_pack(input bit c, input logic [DW-1:0] b[$]);
    int n;
    logic [OW-1:0] word;
    bit l;
    n = b.size();
    for (int w = 0; w * R < n; w++) begin
      word = '0;
      for (int j = 0; j < R; j++) begin
        if (w * R + j < n) word = word | (OW'(b[w*R+j]) << (DW * j));
      end
      l = ((w + 1) * R >= n);
      if (c) exp_cmd.push_back({l, word});
      else   exp_dat.push_back({l, word});
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit l, input bit c, input int gap);
    bit acc;
    if (gap > 0) begin
      chip_dat_vld = 1'b0;
      repeat (gap) tick();
    end
    chip_dat_vld = 1'b1;
    chip_dat_dat = d;
    chip_dat_lst = l;
    chip_dat_cmd = c;
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (chip_dat_rdy) acc = 1'b1;
      tick();
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept: beat %h not accepted within 300 cycles, required accepted", d);
    end
  endtask

  // first beat carries the packet type; later beats get junk on cmd if asked
  task automatic send_pkt(input bit c, input logic [DW-1:0] b[$], input int max_gap, input bit junk_cmd);
    for (int i = 0; i < b.size(); i++) begin
      send_beat(b[i], (i == b.size() - 1), (i == 0) ? c : (junk_cmd ? 1'($urandom_range(0, 1)) : 1'b0),
                (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
    chip_dat_vld = 1'b0;
    chip_dat_lst = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    chip_dat_vld = 1'b0; chip_dat_lst = 1'b0; chip_dat_dat = '0; chip_dat_cmd = 1'b0;
    dat_rdy = 1'b1; cmd_rdy = 1'b1; rand_mode = 1'b0;
    #22;
    checks++;
    if ({chip_dat_rdy, dat_vld, dat_lst, dat_dat, cmd_vld, cmd_lst, cmd_dat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b dv=%b dl=%b dd=%h cv=%b cl=%b cd=%h, required all 0",
               chip_dat_rdy, dat_vld, dat_lst, dat_dat, cmd_vld, cmd_lst, cmd_dat);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (chip_dat_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: chip_dat_rdy=%b, required 1", chip_dat_rdy);
    end
  endtask

  task automatic test_data_packet();
    int base;
    logic [DW-1:0] b[$];
    base = obs_dat.size();
    exp_dat.delete();
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model_pack(1'b0, b);
    for (int i = 0; i < 8; i++) begin
      send_beat(b[i], (i == 7), 1'b0, 0);
      if (i == 3) begin
        checks++;
        if (dat_vld !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: dat_vld=%b one cycle after beat 4, required 0", dat_vld);
        end
      end
      if (i == 4) begin
        checks++;
        if (dat_vld !== 1'b1 || dat_dat !== 32'h04030201 || dat_lst !== 1'b0) begin
          errors++;
          $display("FAIL latency_word: vld=%b dat=%h lst=%b two cycles after beat 4, required 1/04030201/0",
                   dat_vld, dat_dat, dat_lst);
        end
      end
    end
    chip_dat_vld = 1'b0; chip_dat_lst = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs_dat.size() - base != exp_dat.size() || obs_cmd.size() != 0) begin
      errors++;
      $display("FAIL data_pkt_count: dat words=%0d cmd words=%0d, required %0d/0",
               obs_dat.size() - base, obs_cmd.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && base + i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[base+i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL data_pkt_word%0d: got %h, required %h", i, obs_dat[base+i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_partial_tail();
    int base;
    logic [DW-1:0] b[$];
    base = obs_dat.size();
    exp_dat.delete();
    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    model_pack(1'b0, b);
    send_pkt(1'b0, b, 0, 1'b0);
    repeat (5) tick();
    checks++;
    if (obs_dat.size() - base != 2) begin
      errors++;
      $display("FAIL tail_count: got %0d words, required 2", obs_dat.size() - base);
    end
    for (int i = 0; i < exp_dat.size() && base + i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[base+i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL tail_word%0d: got %h, required %h", i, obs_dat[base+i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_command();
    int base;
    logic [OW-1:0] held;
    base = obs_cmd.size();
    cmd_rdy = 1'b0;
    send_beat(8'h11, 1'b0, 1'b1, 0);
    send_beat(8'h22, 1'b0, 1'b0, 0);
    send_beat(8'h33, 1'b0, 1'b0, 0);
    send_beat(8'h44, 1'b1, 1'b0, 0);
    chip_dat_vld = 1'b0; chip_dat_lst = 1'b0;
    tick();
    checks++;
    if (cmd_vld !== 1'b1 || cmd_dat !== 32'h44332211 || cmd_lst !== 1'b1) begin
      errors++;
      $display("FAIL cmd_word: vld=%b dat=%h lst=%b, required 1/44332211/1", cmd_vld, cmd_dat, cmd_lst);
    end
    held = cmd_dat;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (cmd_vld !== 1'b1 || cmd_dat !== held || cmd_lst !== 1'b1 || dat_vld !== 1'b0) begin
        errors++;
        $display("FAIL cmd_hold cycle %0d: cv=%b cd=%h cl=%b dv=%b, required 1/%h/1/0",
                 i, cmd_vld, cmd_dat, cmd_lst, dat_vld, held);
      end
    end
    cmd_rdy = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_vld !== 1'b0 || obs_cmd.size() - base != 1) begin
      errors++;
      $display("FAIL cmd_drain: cmd_vld=%b words=%0d, required 0/1", cmd_vld, obs_cmd.size() - base);
    end else begin
      checks++;
      if (obs_cmd[base] !== {1'b1, 32'h44332211}) begin
        errors++;
        $display("FAIL cmd_taken: got %h, required %h", obs_cmd[base], {1'b1, 32'h44332211});
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [DW-1:0] b[$];
    base = obs_dat.size();
    exp_dat.delete();
    b.delete();
    for (int i = 0; i < 24; i++) b.push_back(DW'(i));
    model_pack(1'b0, b);
    dat_rdy = 1'b0;
    for (int i = 0; i < 20; i++) send_beat(b[i], 1'b0, 1'b0, 0);
    chip_dat_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (chip_dat_rdy !== 1'b0 || dat_vld !== 1'b1 || dat_dat !== 32'h03020100) begin
        errors++;
        $display("FAIL stall cycle %0d: rdy=%b dv=%b head=%h, required 0/1/03020100",
                 i, chip_dat_rdy, dat_vld, dat_dat);
      end
      tick();
    end
    // one-cycle pop while full with a word waiting in the stage
    chip_dat_vld = 1'b1; chip_dat_dat = b[20]; chip_dat_lst = 1'b0; chip_dat_cmd = 1'b0;
    dat_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (chip_dat_rdy !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_rdy: chip_dat_rdy=%b during pop, required 1", chip_dat_rdy);
    end
    tick();
    dat_rdy = 1'b0;
    checks++;
    if (dat_vld !== 1'b1 || dat_dat !== 32'h07060504) begin
      errors++;
      $display("FAIL push_pop_head: dv=%b head=%h, required 1/07060504", dat_vld, dat_dat);
    end
    for (int i = 21; i < 24; i++) send_beat(b[i], (i == 23), 1'b0, 0);
    chip_dat_vld = 1'b0; chip_dat_lst = 1'b0;
    checks++;
    if (chip_dat_rdy !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_occupancy: chip_dat_rdy=%b with full FIFO and stage held, required 0",
               chip_dat_rdy);
    end
    dat_rdy = 1'b1;
    repeat (12) tick();
    checks++;
    if (obs_dat.size() - base != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d words, required 6", obs_dat.size() - base);
    end
    for (int i = 0; i < exp_dat.size() && base + i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[base+i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h, required %h", i, obs_dat[base+i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int base_d;
    int base_c;
    logic [DW-1:0] b[$];
    cmd_rdy = 1'b0;
    dat_rdy = 1'b1;
    b = '{8'hC7};
    send_pkt(1'b1, b, 0, 1'b0);
    send_beat(8'h99, 1'b0, 1'b0, 0);
    send_beat(8'h9A, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({chip_dat_rdy, dat_vld, dat_lst, dat_dat, cmd_vld, cmd_lst, cmd_dat} !== '0) begin
      errors++;
      $display("FAIL midpkt_reset_outputs: rdy=%b dv=%b dl=%b dd=%h cv=%b cl=%b cd=%h, required all 0",
               chip_dat_rdy, dat_vld, dat_lst, dat_dat, cmd_vld, cmd_lst, cmd_dat);
    end
    chip_dat_vld = 1'b0;
    cmd_rdy = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    base_d = obs_dat.size();
    base_c = obs_cmd.size();
    b = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(1'b0, b, 0, 1'b0);
    repeat (5) tick();
    checks++;
    if (obs_dat.size() - base_d != 1 || obs_cmd.size() - base_c != 0) begin
      errors++;
      $display("FAIL midpkt_count: dat words=%0d cmd words=%0d, required 1/0",
               obs_dat.size() - base_d, obs_cmd.size() - base_c);
    end else begin
      checks++;
      if (obs_dat[base_d] !== {1'b1, 32'h88776655}) begin
        errors++;
        $display("FAIL midpkt_word: got %h, required %h", obs_dat[base_d], {1'b1, 32'h88776655});
      end
    end
  endtask

  task automatic test_random();
    int base_d;
    int base_c;
    logic [DW-1:0] b[$];
    bit c;
    base_d = obs_dat.size();
    base_c = obs_cmd.size();
    exp_dat.delete();
    exp_cmd.delete();
    rand_mode = 1'b1;
    for (int p = 0; p < 16; p++) begin
      b.delete();
      c = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) b.push_back(DW'($urandom));
      model_pack(c, b);
      send_pkt(c, b, 2, 1'b1);
    end
    rand_mode = 1'b0;
    dat_rdy = 1'b1;
    cmd_rdy = 1'b1;
    repeat (30) tick();
    checks++;
    if (obs_dat.size() - base_d != exp_dat.size() || obs_cmd.size() - base_c != exp_cmd.size()) begin
      errors++;
      $display("FAIL rand_count: dat=%0d cmd=%0d, required %0d/%0d",
               obs_dat.size() - base_d, obs_cmd.size() - base_c, exp_dat.size(), exp_cmd.size());
    end
    for (int i = 0; i < exp_dat.size() && base_d + i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[base_d+i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL rand_dat%0d: got %h, required %h", i, obs_dat[base_d+i], exp_dat[i]);
      end
    end
    for (int i = 0; i < exp_cmd.size() && base_c + i < obs_cmd.size(); i++) begin
      checks++;
      if (obs_cmd[base_c+i] !== exp_cmd[i]) begin
        errors++;
        $display("FAIL rand_cmd%0d: got %h, required %h", i, obs_cmd[base_c+i], exp_cmd[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_data_packet();
    test_partial_tail();
    test_command();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeg_chip_rx.md
Name: eeg_chip_rx

Overview:
- Pad-side receive stage of EEG_TOP, directly downstream of the CHIP_DAT_* input pads.
- Accepts the narrow chip input stream (vld/lst/rdy/dat/cmd) and packs CHIP_DAT_DW-bit beats into OUT_DW-bit words.
- Routes each packet to either the data path or the command path. Data words go through a small FIFO toward the accelerator core; command words go through a single-entry register toward the config logic.

Parameters:
CHIP_DAT_DW, 8, pad data beat width
OUT_DW, 32, packed word width; OUT_DW/CHIP_DAT_DW = RATIO, integer, must be >= 2
FIFO_DEPTH, 4, data FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
chip_dat_vld  in  1  pad beat valid
chip_dat_lst  in  1  last beat of packet
chip_dat_dat  in  CHIP_DAT_DW  pad beat data
chip_dat_cmd  in  1  packet type (1 = command), sampled on first beat only
chip_dat_rdy  out  1  beat accepted when vld & rdy
dat_vld  out  1  data word valid (FIFO head)
dat_lst  out  1  word holds last beat of its packet
dat_dat  out  OUT_DW  data word
dat_rdy  in  1  consumer ready
cmd_vld  out  1  command word valid
cmd_lst  out  1  last word of command packet
cmd_dat  out  OUT_DW  command word
cmd_rdy  in  1  config consumer ready

Behaviour:
- Reset (async assert, sync release): all outputs 0. FIFO empty, packer cnt=0, in_pkt=0, stage empty, cmd register empty. Reset mid-packet discards the partial word and all buffered words.
- Packer holds shift register sreg[OUT_DW], beat counter cnt[log2 RATIO], in_pkt, pkt_cmd.
- Accepted beat k lands in bits [k*CHIP_DAT_DW +: CHIP_DAT_DW]; first beat goes in the LSBs.
- First accepted beat with in_pkt=0 latches pkt_cmd = chip_dat_cmd and sets in_pkt. chip_dat_cmd on later beats is ignored.
- A word completes on an accepted beat with cnt==RATIO-1 or chip_dat_lst=1. On completion:
  - the word moves to the stage register with lst = chip_dat_lst and type = pkt_cmd;
  - bits above the last written beat are forced to 0;
  - cnt returns to 0; lst also clears in_pkt.
- Stage push:
  - type=0 pushes into the FIFO when not full.
  - type=1 loads the cmd register when it is empty or being drained this cycle (cmd_vld & cmd_rdy).
- chip_dat_rdy = !stage_vld | stage_push. It depends only on internal state, dat_rdy and cmd_rdy, never on chip_dat_vld. At RATIO>=2 with free destinations, chip_dat_rdy stays 1 continuously.
- Latency: completing beat sampled at edge E → stage valid after E → dat_vld or cmd_vld high after E+1 (2 cycles).
- FIFO:
  - dat_vld = !empty; dat_dat/dat_lst show the head; pop on dat_vld & dat_rdy.
  - Simultaneous push and pop when full is allowed (pop frees the slot in the same cycle). Occupancy is unchanged; words are never lost or reordered.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
- cmd register: cmd_vld held until cmd_rdy. cmd_dat/cmd_lst stay stable while cmd_vld & !cmd_rdy.
- A blocked destination stalls only through the stage. Packet order across the two paths is preserved at the stage, so a pending command blocks a following data word.
- Output data is stable while vld=1 and rdy=0 on both output interfaces.

Test Plan:
1. Data packet: 8 beats 0x01..0x08, cmd=0, lst on beat 8, dat_rdy=1 → dat words 0x04030201 (lst=0) then 0x08070605 (lst=1). cmd_vld never 1. First dat_vld 2 cycles after beat 4.
2. Partial tail: 6 beats 0xA1..0xA6, lst on 6th → 0xA4A3A2A1 (lst=0), 0x0000A6A5 (lst=1).
3. Command: 4 beats 0x11,0x22,0x33,0x44 with cmd=1 on beat 1 only, lst on beat 4 → cmd_dat=0x44332211, cmd_lst=1, dat_vld stays 0. With cmd_rdy=0 for 10 cycles, cmd_vld/cmd_dat are held unchanged.
4. Backpressure: dat_rdy=0, stream 24 continuous beats 0x00..0x17 (lst on last) → FIFO holds 4 words and the 5th word sits in stage. chip_dat_rdy=0 from the cycle after beat 20 is accepted until dat_rdy rises. After release, all 6 words 0x03020100..0x17161514 arrive in order and only the last has lst=1.
5. Full with simultaneous push/pop: FIFO full, dat_rdy=1 for one cycle while stage holds a word → one pop and one push in that cycle, occupancy stays 4, no word dropped.
6. Reset mid-packet: drop rst_n after 2 beats of a data packet → all outputs 0 immediately. After release, a new 4-beat packet 0x55,0x66,0x77,0x88 (lst on beat 4) yields exactly one word 0x88776655 with lst=1, with no residue from the aborted packet.
